// File: rtl/clk_div_multi_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV  = 2;
  localparam int LOCK_MAX = 15;
  localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

  function automatic logic [31:0] ceil_half(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// Divisor configuration handshake between a host and the divider.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 16
) ();

  localparam int CH_W = ch_w(NUM_CH);

  logic             cfg_valid_i;
  logic [CH_W-1:0]  cfg_ch_i;
  logic [DIV_W-1:0] cfg_div_i;
  logic             cfg_ready_o;
  logic             cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_ch_i,
    output cfg_div_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_ch_i,
    input  cfg_div_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/clk_div_multi_ch.sv
// One divider channel: counter, divisor and pending registers,
// tick / divided-clock flops and lock counter.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 30,
  parameter int LOCK_PERIODS = 2
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_div_i,
  output logic             pend_o,
  output logic             tick_o,
  output logic             clk_o,
  output logic             lock_o
);

  localparam logic [DIV_W-1:0]  DEF = DIV_W'(DEFAULT_DIV);
  localparam logic [LOCK_W-1:0] LP  = LOCK_W'(LOCK_PERIODS);

  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  pend_div;
  logic [DIV_W-1:0]  cnt_nxt;
  logic [DIV_W-1:0]  div_nxt;
  logic [DIV_W:0]    half;
  logic              pend_vld;
  logic              wrap;
  logic              apply;
  logic [LOCK_W-1:0] lock_cnt;
  logic [LOCK_W-1:0] lock_inc;

  assign wrap    = (cnt == div - 1'b1);
  // a pending divisor lands on wrap, sync, or any disabled edge
  assign apply   = pend_vld & (~en_i | sync_i | wrap);
  assign div_nxt = apply ? pend_div : div;
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
  assign half    = (DIV_W+1)'(ceil_half(32'(div_nxt)));
  assign lock_inc = (lock_cnt == LP) ? lock_cnt
                                     : lock_cnt + 1'b1;
  assign pend_o  = pend_vld;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div      <= DEF;
      pend_div <= DEF;
      pend_vld <= 1'b0;
      tick_o   <= 1'b0;
      clk_o    <= 1'b0;
      lock_cnt <= '0;
      lock_o   <= 1'b0;
    end else begin
      div <= div_nxt;
      if (load_i) begin
        pend_vld <= 1'b1;
        pend_div <= load_div_i;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
      if (!en_i) begin
        cnt      <= '0;
        tick_o   <= 1'b0;
        clk_o    <= 1'b0;
        lock_cnt <= '0;
        lock_o   <= 1'b0;
      end else if (sync_i) begin
        cnt      <= '0;
        tick_o   <= 1'b1;
        clk_o    <= 1'b1;
        lock_cnt <= '0;
        lock_o   <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        tick_o <= wrap;
        clk_o  <= ({1'b0, cnt_nxt} < half);
        if (apply) begin
          lock_cnt <= '0;
          lock_o   <= 1'b0;
        end else if (wrap) begin
          lock_cnt <= lock_inc;
          lock_o   <= (lock_inc == LP);
        end
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable tick / divided-clock generator:
// config decode, ready mux and error flag around NUM_CH channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = 16,
  parameter int DEFAULT_DIV  = 30,
  parameter int LOCK_PERIODS = 2
) (
  input  logic              clkin,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] lock_o
);

  localparam int CH_W  = ch_w(NUM_CH);
  localparam int SEL_N = 1 << CH_W;
  localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

  logic [NUM_CH-1:0] pend;
  logic [SEL_N-1:0]  pend_pad;
  logic              in_range;
  logic              div_ok;
  logic              accept;
  logic              err_q;

  // padded so an out-of-range select still reads a defined bit
  assign pend_pad = SEL_N'(pend);
  assign in_range = ({1'b0, cfg.cfg_ch_i} < CH_LIM);
  assign div_ok   = (cfg.cfg_div_i >= DIV_W'(MIN_DIV));
  assign cfg.cfg_ready_o = in_range & ~pend_pad[cfg.cfg_ch_i];
  assign accept   = cfg.cfg_valid_i & cfg.cfg_ready_o;
  assign cfg.cfg_err_o = err_q;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= cfg.cfg_valid_i &
               (~in_range | (accept & ~div_ok));
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .LOCK_PERIODS(LOCK_PERIODS)
    ) u_ch (
      .clkin     (clkin),
      .reset     (reset),
      .en_i      (en_i[i]),
      .sync_i    (sync_i),
      .load_i    (accept & div_ok &
                  (cfg.cfg_ch_i == CH_W'(i))),
      .load_div_i(cfg.cfg_div_i),
      .pend_o    (pend[i]),
      .tick_o    (tick_o[i]),
      .clk_o     (clk_o[i]),
      .lock_o    (lock_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: phase-based reference model, config
// vector table, directed corner sequences and random stimulus.
module tb_clk_div_multi;

  localparam int LP  = 2;
  localparam int DEF = 30;

  logic       clkin;
  logic       reset;
  logic [1:0] en_i;
  logic       sync_i;
  logic [1:0] tick_o, clk_o, lock_o;
  logic [2:0] en3, tick3, clk3, lock3;

  int n_chk = 0;
  int n_err = 0;

  clk_div_multi_if #(.NUM_CH(2), .DIV_W(16)) cfg ();
  clk_div_multi_if #(.NUM_CH(3), .DIV_W(16)) cfg3 ();

  clk_div_multi #(.NUM_CH(2), .DIV_W(16),
    .DEFAULT_DIV(DEF), .LOCK_PERIODS(LP)) dut (
    .clkin(clkin), .reset(reset), .en_i(en_i),
    .sync_i(sync_i), .cfg(cfg), .tick_o(tick_o),
    .clk_o(clk_o), .lock_o(lock_o));

  clk_div_multi #(.NUM_CH(3), .DIV_W(16),
    .DEFAULT_DIV(DEF), .LOCK_PERIODS(LP)) dut3 (
    .clkin(clkin), .reset(reset), .en_i(en3),
    .sync_i(1'b0), .cfg(cfg3), .tick_o(tick3),
    .clk_o(clk3), .lock_o(lock3));

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // model: phase within the period, divisor, pending slot, ticks seen
  int m_div[2], m_pdiv[2], m_pos[2], m_ticks[2];
  bit m_pv[2], m_act[2];
  bit m_err;
  logic [1:0] m_tick, m_clk, m_lock;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      m_div[c] = DEF; m_pv[c] = 0; m_pdiv[c] = 0;
      m_pos[c] = 0; m_act[c] = 0; m_ticks[c] = 0;
    end
    m_err = 0; m_tick = 0; m_clk = 0; m_lock = 0;
  endtask

  function automatic bit m_ready(int ch);
    return ch < 2 && !m_pv[ch];
  endfunction

  task automatic m_step(logic [1:0] en, bit sy, bit v,
                        int ch, int d);
    bit acc;
    acc = v && m_ready(ch);
    m_err = v && (ch >= 2 || (acc && d < 2));
    for (int c = 0; c < 2; c++) begin
      if (!en[c]) begin
        if (m_pv[c]) begin m_div[c] = m_pdiv[c]; m_pv[c] = 0; end
        m_pos[c] = 0; m_act[c] = 0; m_ticks[c] = 0;
      end else if (sy) begin
        if (m_pv[c]) begin m_div[c] = m_pdiv[c]; m_pv[c] = 0; end
        m_pos[c] = 0; m_act[c] = 1; m_ticks[c] = 0;
      end else begin
        m_act[c] = 1;
        if (m_pos[c] == m_div[c] - 1) begin
          m_pos[c] = 0;
          if (m_pv[c]) begin
            m_div[c] = m_pdiv[c]; m_pv[c] = 0; m_ticks[c] = 0;
          end else if (m_ticks[c] < LP) begin
            m_ticks[c]++;
          end
        end else begin
          m_pos[c]++;
        end
      end
      if (acc && ch == c && d >= 2) begin
        m_pv[c] = 1; m_pdiv[c] = d;
      end
      m_tick[c] = m_act[c] && m_pos[c] == 0;
      m_clk[c]  = m_act[c] && m_pos[c] < (m_div[c] + 1) / 2;
      m_lock[c] = m_ticks[c] >= LP;
    end
  endtask

  task automatic cycle();
    logic [1:0] en; bit sy, v; int ch, d;
    #1;
    chk("ready", cfg.cfg_ready_o, m_ready(cfg.cfg_ch_i));
    en = en_i; sy = sync_i; v = cfg.cfg_valid_i;
    ch = cfg.cfg_ch_i; d = cfg.cfg_div_i;
    @(posedge clkin); #1;
    m_step(en, sy, v, ch, d);
    chk("tick", tick_o, m_tick);
    chk("clk", clk_o, m_clk);
    chk("lock", lock_o, m_lock);
    chk("err", cfg.cfg_err_o, m_err);
  endtask

  task automatic wr(int ch, int d);
    int n;
    n = 0;
    cfg.cfg_ch_i = ch[0]; cfg.cfg_div_i = 16'(d);
    #1;
    while (!cfg.cfg_ready_o && n < 64) begin
      cycle(); #1; n++;
    end
    chk("wr_ready_wait", cfg.cfg_ready_o, 1);
    cfg.cfg_valid_i = 1'b1;
    cycle();
    cfg.cfg_valid_i = 1'b0;
  endtask

  typedef struct {
    bit v; int ch; int d; bit rdy; bit err;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int t0, t1, co, hi, n;
    bit found;
    tbl[0] = '{1, 0, 8, 1, 0};
    tbl[1] = '{1, 0, 9, 0, 0};
    tbl[2] = '{1, 1, 1, 1, 1};
    tbl[3] = '{1, 1, 6, 1, 0};
    tbl[4] = '{1, 1, 7, 0, 0};
    tbl[5] = '{0, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0};

    reset = 1; en_i = 0; sync_i = 0; en3 = 0;
    cfg.cfg_valid_i = 0; cfg.cfg_ch_i = 0; cfg.cfg_div_i = 0;
    cfg3.cfg_valid_i = 0; cfg3.cfg_ch_i = 0;
    cfg3.cfg_div_i = 0;
    m_reset();
    repeat (2) @(posedge clkin);
    #1 reset = 0;
    #1;
    chk("rst_tick", tick_o, 0);
    chk("rst_clk", clk_o, 0);
    chk("rst_lock", lock_o, 0);
    chk("rst_err", cfg.cfg_err_o, 0);
    chk("rst_ready", cfg.cfg_ready_o, 1);

    // default divisor: first tick at edge 30, lock on 2nd tick
    en_i = 2'b11;
    hi = 0;
    for (int k = 1; k <= 60; k++) begin
      cycle();
      if (k > 30) hi += clk_o[0];
      if (k == 29) chk("d30_no_tick", tick_o[0], 0);
      if (k == 30) chk("d30_tick1", tick_o[0], 1);
      if (k == 59) chk("d30_lock_pre", lock_o[0], 0);
      if (k == 60) chk("d30_lock", lock_o[0], 1);
    end
    chk("d30_high15", hi, 15);

    // mid-period write of D=5 on ch1 waits for the wrap
    repeat (7) cycle();
    wr(1, 5);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      found = tick_o[1];
    end
    chk("d5_applied", found, 1);
    chk("d5_lock_drop", lock_o[1], 0);
    t1 = 0; hi = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      t1 += tick_o[1]; hi += clk_o[1];
    end
    chk("d5_ticks", t1, 4);
    chk("d5_high", hi, 12);

    // config vector table right after a sync
    sync_i = 1; cycle(); sync_i = 0;
    chk("sync_tick", tick_o, 2'b11);
    foreach (tbl[i]) begin
      cfg.cfg_valid_i = tbl[i].v;
      cfg.cfg_ch_i = tbl[i].ch[0];
      cfg.cfg_div_i = 16'(tbl[i].d);
      #1;
      chk("tbl_ready", cfg.cfg_ready_o, tbl[i].rdy);
      cycle();
      chk("tbl_err", cfg.cfg_err_o, tbl[i].err);
    end
    cfg.cfg_valid_i = 0;

    // out-of-range channel on a 3-channel instance
    cfg3.cfg_valid_i = 1; cfg3.cfg_ch_i = 2'd3;
    cfg3.cfg_div_i = 16'd10;
    #1;
    chk("oor_ready", cfg3.cfg_ready_o, 0);
    cycle();
    chk("oor_err", cfg3.cfg_err_o, 1);
    cfg3.cfg_ch_i = 2'd2;
    #1;
    chk("ch2_ready", cfg3.cfg_ready_o, 1);
    cycle();
    cfg3.cfg_valid_i = 0;
    chk("ch2_no_err", cfg3.cfg_err_o, 0);

    n = 0;
    while (!cfg.cfg_ready_o && n < 40) begin
      cycle(); #1; n++;
    end
    chk("ch0_ready_back", cfg.cfg_ready_o, 1);

    // sync aligns D=30 and D=10
    wr(0, 30);
    wr(1, 10);
    sync_i = 1; cycle(); sync_i = 0;
    chk("sync_tick2", tick_o, 2'b11);
    chk("sync_clk2", clk_o, 2'b11);
    t0 = 0; t1 = 0; co = 0;
    for (int k = 0; k < 60; k++) begin
      cycle();
      t0 += tick_o[0]; t1 += tick_o[1];
      co += tick_o[0] & tick_o[1];
    end
    chk("align_t0", t0, 2);
    chk("align_t1", t1, 6);
    chk("align_co", co, 2);

    // disable mid-period, pending write while disabled
    repeat (4) cycle();
    en_i = 2'b01;
    cycle();
    chk("dis_tick", tick_o[1], 0);
    chk("dis_clk", clk_o[1], 0);
    chk("dis_lock", lock_o[1], 0);
    wr(1, 4);
    #1;
    chk("dis_pend", cfg.cfg_ready_o, 0);
    cycle(); #1;
    chk("dis_apply", cfg.cfg_ready_o, 1);
    en_i = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      chk("reen_tick", tick_o[1], k == 4);
    end

    // async reset with an update pending
    wr(0, 12);
    repeat (3) cycle();
    #2 reset = 1;
    #1;
    chk("arst_tick", tick_o, 0);
    chk("arst_clk", clk_o, 0);
    chk("arst_lock", lock_o, 0);
    chk("arst_err", cfg.cfg_err_o, 0);
    chk("arst_ready", cfg.cfg_ready_o, 1);
    @(posedge clkin); #1;
    reset = 0;
    m_reset();
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (k == 12) chk("arst_no12", tick_o[0], 0);
      if (k == 30) chk("arst_def", tick_o[0], 1);
    end

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 49) == 0)
        en_i[$urandom_range(0, 1)] ^= 1'b1;
      sync_i = ($urandom_range(0, 39) == 0);
      cfg.cfg_valid_i = ($urandom_range(0, 2) == 0);
      cfg.cfg_ch_i = 1'($urandom_range(0, 1));
      cfg.cfg_div_i = 16'($urandom_range(0, 9));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
